// File: rtl/bp_upd_pkg.sv
// Shared types and constants for the branch-predictor update scheduler.
// One update record travels unchanged from a requester to the predictor port.
package bp_upd_pkg;

    localparam int PCW   = 32;
    localparam int NREQ  = 2;
    localparam int DROPW = 8;

    typedef struct packed {
        logic [PCW-1:0] pc, bt;
        logic           taken;
    } bp_upd_t;

    // Saturating add: stops at all-ones instead of wrapping.
    function automatic logic [DROPW-1:0] satAdd(input logic [DROPW-1:0] base,
                                                input logic [DROPW-1:0] inc);
        logic [DROPW:0] sum;
        sum = {1'b0, base} + {1'b0, inc};
        return sum[DROPW] ? {DROPW{1'b1}} : sum[DROPW-1:0];
    endfunction

endpackage

// File: rtl/bp_update_sched_if.sv
// Requester-side handshake bundle plus the predictor resolution port.
// master = requesters/predictor environment, slave = the scheduler.
interface bp_update_sched_if;
    import bp_upd_pkg::*;

    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0][PCW-1:0]  req_pc;
    logic [NREQ-1:0][PCW-1:0]  req_bt;
    logic [NREQ-1:0]           req_taken;
    logic [NREQ-1:0]           req_ready;

    logic                      enable_res;
    logic [PCW-1:0]            pc_res;
    logic [PCW-1:0]            bt_res;
    logic                      taken_res;

    modport master (
        output req_valid, req_pc, req_bt, req_taken,
        input  req_ready, enable_res, pc_res, bt_res, taken_res
    );

    modport slave (
        input  req_valid, req_pc, req_bt, req_taken,
        output req_ready, enable_res, pc_res, bt_res, taken_res
    );

endinterface

// File: rtl/bp_upd_fifo.sv
// Small circular FIFO of update records with a synchronous clear.
// Pushes into a full FIFO and pops from an empty one are ignored.
module bp_upd_fifo
    import bp_upd_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = bp_upd_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  T                       i_pushData,
    input  logic                   i_pop,
    input  logic                   i_clear,
    output T                       o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    T               r_mem [DEPTH];
    logic [AW-1:0]  r_wrPtr;
    logic [AW-1:0]  r_rdPtr;
    logic [AW:0]    r_count;

    logic           w_doPush;
    logic           w_doPop;

    assign o_full   = (r_count == FULL_CNT);
    assign o_empty  = (r_count == '0);
    assign w_doPush = i_push && !o_full && !i_clear;
    assign w_doPop  = i_pop && !o_empty && !i_clear;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_doPush} - {{AW{1'b0}}, w_doPop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr] <= i_pushData;
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_count = r_count;

endmodule

// File: rtl/bp_update_sched.sv
// Round-robin scheduler that funnels two branch-resolution requesters into the
// predictor's single update port through a FIFO drained one entry per cycle.
module bp_update_sched
    import bp_upd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    CLK,
    input  logic                    nRST,
    bp_update_sched_if.slave        bus,
    input  logic                    upd_hold,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic [DROPW-1:0]        drop_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic              r_rrPtr;
    logic [DROPW-1:0]  r_dropCnt;

    logic              w_full;
    logic              w_empty;
    logic              w_grantOk;
    logic              w_bothValid;
    logic [NREQ-1:0]   w_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_sel;
    bp_upd_t           w_pushData;
    bp_upd_t           w_head;
    logic [CW-1:0]     w_count;

    // Grant never looks at the same-cycle drain, so a full FIFO blocks enqueue.
    // Ready is also held low while reset is asserted.
    always_comb begin
        w_grantOk   = nRST && !flush && !w_full;
        w_bothValid = &bus.req_valid;
        w_ready     = '0;
        if (w_grantOk) begin
            if (w_bothValid) w_ready[r_rrPtr] = 1'b1;
            else             w_ready          = bus.req_valid;
        end
    end

    always_comb begin
        w_sel            = w_ready[1];
        w_push           = |w_ready;
        w_pushData.pc    = bus.req_pc[w_sel];
        w_pushData.bt    = bus.req_bt[w_sel];
        w_pushData.taken = bus.req_taken[w_sel];
        w_pop            = !w_empty && !upd_hold && !flush;
    end

    bp_upd_fifo #(
        .DEPTH (DEPTH),
        .T     (bp_upd_t)
    ) u_fifo (
        .clk        (CLK),
        .rst_n      (nRST),
        .i_push     (w_push),
        .i_pushData (w_pushData),
        .i_pop      (w_pop),
        .i_clear    (flush),
        .o_head     (w_head),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // Only a contested grant moves the round-robin pointer; flush re-arms it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rrPtr   <= 1'b0;
            r_dropCnt <= '0;
        end else if (flush) begin
            r_rrPtr   <= 1'b0;
            r_dropCnt <= satAdd(r_dropCnt, DROPW'(w_count));
        end else if (w_push && w_bothValid) begin
            r_rrPtr   <= ~r_rrPtr;
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.enable_res = w_pop;
    assign bus.pc_res     = w_empty ? '0 : w_head.pc;
    assign bus.bt_res     = w_empty ? '0 : w_head.bt;
    assign bus.taken_res  = w_empty ? 1'b0 : w_head.taken;
    assign occupancy      = w_count;
    assign drop_cnt       = r_dropCnt;

    a_oneGrant: assert property (@(posedge CLK) disable iff (!nRST)
        $onehot0(bus.req_ready));
    a_noDrainOnFlush: assert property (@(posedge CLK) disable iff (!nRST)
        bus.enable_res |-> !flush);
    a_occBound: assert property (@(posedge CLK) disable iff (!nRST)
        occupancy <= CW'(DEPTH));

endmodule
